rng_seed_collector: RTL
=======================

Name: rng_seed_collector

Overview:
- Sits directly downstream of the 128-bit ring-oscillator RNG array and drives its enable.
- On request, it runs the generator, discards warm-up words, and collects NUM_SAMPLES raw 128-bit words.
- Each word is health-tested (stuck, repetition, popcount bias) and folded into one 128-bit seed.
- The seed is delivered to the key/nonce logic over a valid/ready handshake.

Parameters:
- DISCARD, 2: cycles of generator output ignored after rng_enable rises (1..15).
- NUM_SAMPLES, 4: raw words folded into one seed (1..15).
- POP_TOL, 32: allowed deviation of a word's popcount from 64.
- BAD_LIMIT, 2: popcount-out-of-range words per request that trigger failure (1..15).

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: seed request; sampled only in IDLE.
- raw_bits, input, 128: generator output.
- rng_enable, output, 1: enable to the generator; registered.
- seed, output, 128: folded seed; stable while seed_valid=1.
- seed_valid, output, 1: seed available.
- seed_ready, input, 1: consumer accepts seed.
- busy, output, 1: high in any state except IDLE.
- health_fail, output, 1: sticky failure flag.
- fail_code, output, 2: 0 none, 1 stuck, 2 repeat, 3 popcount.
- clear_fail, input, 1: exits FAIL.

Behaviour:
- Reset (async, rst=1): state=IDLE; rng_enable=0, seed=0, seed_valid=0, busy=0, health_fail=0, fail_code=0; all counters, the previous-word register and the accumulator cleared. Reset mid-operation aborts immediately; no partial seed survives.
- States: IDLE, WARMUP, SAMPLE, VALID, FAIL.
- IDLE: start=1 -> WARMUP next cycle. On that edge: rng_enable<=1, accumulator<=0, sample count<=0, bad count<=0.
- WARMUP: runs DISCARD cycles (counter), then -> SAMPLE. raw_bits ignored.
- SAMPLE: exactly NUM_SAMPLES cycles; raw_bits is captured every cycle.
  - Fold: acc <= {acc[126:0],acc[127]} ^ raw_bits.
  - The previous-word register is loaded with raw_bits.
  - On the last sample edge: rng_enable<=0, seed<=folded value, seed_valid<=1, state -> VALID.
- Health tests, evaluated combinationally on each SAMPLE-cycle word:
  - Stuck: word all-0 or all-1.
  - Repeat: word equals the previous word. Applies from the second sample of a request only.
  - Popcount: ones count outside [64-POP_TOL, 64+POP_TOL]. bad count increments; failure when the incremented count >= BAD_LIMIT.
- Failure is detected on the failing word's edge.
  - Next state is FAIL; that word is not folded.
  - Priority when several fail at once: stuck > repeat > popcount.
- FAIL:
  - rng_enable=0, seed=0, seed_valid=0.
  - health_fail=1 and fail_code held.
  - start ignored.
  - clear_fail=1 -> IDLE; health_fail and fail_code are cleared on the same edge.
- VALID:
  - Transfer occurs on a cycle with seed_valid && seed_ready.
  - On that edge: seed_valid<=0, state -> IDLE; seed keeps its value until the next request's VALID entry.
  - seed_ready while not valid has no effect.
  - start is ignored in VALID, and in all states other than IDLE.
- Latency: start edge to seed_valid = 1 + DISCARD + NUM_SAMPLES cycles (default 7). A new start is accepted on the cycle after transfer at the earliest.
- Arithmetic: popcount is 8-bit unsigned. Counters saturate-free, sized to 4 bits. Rotation wraps bit 127 to bit 0.

Test Plan:
- Normal request, defaults: raw words after warm-up A=0x0123..EF pattern, B, C, D (each popcount 64, distinct); seed_ready=1. Expect:
  - seed_valid at cycle 7 after start.
  - seed = rotl(rotl(rotl(A)^B)^C)^D.
  - rng_enable high exactly cycles 1-6.
- Stuck word: third sample = 128'h0 -> FAIL; health_fail=1, fail_code=1, seed_valid never rises, rng_enable=0. clear_fail -> IDLE with flags 0.
- Repeat: second sample equals first (0xA5A5...A5) -> fail_code=2. Identical word across two separate requests -> no failure.
- Bias: two words with popcount 20 (POP_TOL=32) -> fail_code=3 on the second. A single such word still yields seed_valid.
- Backpressure: seed_ready=0 for 10 cycles after valid -> seed and seed_valid stable, start pulses ignored; transfer on seed_ready=1, then a new start is accepted next cycle.
- Async reset asserted in SAMPLE mid-cycle -> all outputs 0 immediately. After release, a new start produces a seed from fresh words only.

Source files
------------

// File: rtl/rng_seed_collector.sv
// rng_seed_collector: drives the ring-oscillator RNG enable, discards warm-up
// output, health-tests NUM_SAMPLES raw words and folds them into a 128-bit seed
// that is handed to the key/nonce logic over a valid/ready handshake.
module rng_seed_collector #(
    parameter int DISCARD     = 2,
    parameter int NUM_SAMPLES = 4,
    parameter int POP_TOL     = 32,
    parameter int BAD_LIMIT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] raw_bits,
    output logic         rng_enable,
    output logic [127:0] seed,
    output logic         seed_valid,
    input  logic         seed_ready,
    output logic         busy,
    output logic         health_fail,
    output logic [1:0]   fail_code,
    input  logic         clear_fail
);

    typedef enum logic [2:0] {IDLE, WARMUP, SAMPLE, VALID, FAIL} state_t;

    localparam logic [3:0] WARM_LAST   = 4'(DISCARD - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(NUM_SAMPLES - 1);
    localparam logic [3:0] BAD_LIM     = 4'(BAD_LIMIT);
    localparam logic [7:0] POP_LO      = 8'(64 - POP_TOL);
    localparam logic [7:0] POP_HI      = 8'(64 + POP_TOL);

    state_t        state_q, state_d;
    logic [3:0]    warm_cnt_q, warm_cnt_d;
    logic [3:0]    sample_cnt_q, sample_cnt_d;
    logic [3:0]    bad_q, bad_d;
    logic [127:0]  acc_q, acc_d;
    logic [127:0]  prev_q, prev_d;
    logic [127:0]  seed_q, seed_d;
    logic          seed_valid_q, seed_valid_d;
    logic          rng_enable_q, rng_enable_d;
    logic          busy_q, busy_d;
    logic          health_fail_q, health_fail_d;
    logic [1:0]    fail_code_q, fail_code_d;

    logic [7:0]    pop;
    logic          is_stuck, is_repeat, is_biased, pop_fail;
    logic [3:0]    bad_inc;
    logic [127:0]  acc_fold;

    // Ones count of the current generator word.
    always_comb begin
        pop = '0;
        for (int i = 0; i < 128; i++) begin
            pop = pop + {7'd0, raw_bits[i]};
        end
    end

    // Health tests and the rotate-xor fold for the word presented this cycle.
    always_comb begin
        is_stuck  = (raw_bits == '0) || (raw_bits == '1);
        // The previous-word register is stale on the first sample of a request.
        is_repeat = (sample_cnt_q != 4'd0) && (raw_bits == prev_q);
        is_biased = (pop < POP_LO) || (pop > POP_HI);
        bad_inc   = bad_q + 4'd1;
        pop_fail  = is_biased && (bad_inc >= BAD_LIM);
        acc_fold  = {acc_q[126:0], acc_q[127]} ^ raw_bits;
    end

    // Next-state and next-output logic for the request sequencer.
    always_comb begin
        state_d       = state_q;
        warm_cnt_d    = warm_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        bad_d         = bad_q;
        acc_d         = acc_q;
        prev_d        = prev_q;
        seed_d        = seed_q;
        seed_valid_d  = seed_valid_q;
        rng_enable_d  = rng_enable_q;
        health_fail_d = health_fail_q;
        fail_code_d   = fail_code_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = WARMUP;
                    rng_enable_d = 1'b1;
                    acc_d        = '0;
                    warm_cnt_d   = '0;
                    sample_cnt_d = '0;
                    bad_d        = '0;
                end
            end
            WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d    = SAMPLE;
                    warm_cnt_d = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                prev_d = raw_bits;
                if (is_stuck || is_repeat || pop_fail) begin
                    // A failing word is never folded; the partial seed is dropped.
                    state_d       = FAIL;
                    rng_enable_d  = 1'b0;
                    seed_d        = '0;
                    seed_valid_d  = 1'b0;
                    health_fail_d = 1'b1;
                    fail_code_d   = is_stuck ? 2'd1 : (is_repeat ? 2'd2 : 2'd3);
                end else begin
                    acc_d = acc_fold;
                    if (is_biased) bad_d = bad_inc;
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        state_d      = VALID;
                        rng_enable_d = 1'b0;
                        seed_d       = acc_fold;
                        seed_valid_d = 1'b1;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 4'd1;
                    end
                end
            end
            VALID: begin
                if (seed_ready) begin
                    state_d      = IDLE;
                    seed_valid_d = 1'b0;
                end
            end
            FAIL: begin
                if (clear_fail) begin
                    state_d       = IDLE;
                    health_fail_d = 1'b0;
                    fail_code_d   = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            warm_cnt_q    <= '0;
            sample_cnt_q  <= '0;
            bad_q         <= '0;
            acc_q         <= '0;
            prev_q        <= '0;
            seed_q        <= '0;
            seed_valid_q  <= 1'b0;
            rng_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            health_fail_q <= 1'b0;
            fail_code_q   <= 2'd0;
        end else begin
            state_q       <= state_d;
            warm_cnt_q    <= warm_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            bad_q         <= bad_d;
            acc_q         <= acc_d;
            prev_q        <= prev_d;
            seed_q        <= seed_d;
            seed_valid_q  <= seed_valid_d;
            rng_enable_q  <= rng_enable_d;
            busy_q        <= busy_d;
            health_fail_q <= health_fail_d;
            fail_code_q   <= fail_code_d;
        end
    end

    assign rng_enable  = rng_enable_q;
    assign seed        = seed_q;
    assign seed_valid  = seed_valid_q;
    assign busy        = busy_q;
    assign health_fail = health_fail_q;
    assign fail_code   = fail_code_q;

endmodule
